// File: rtl/perf_counter_bank.sv
// Performance-monitor counter bank: cycle, retired-instruction and NUM_CH event counters
// with halt/timeout freeze and registered readback. Define PERF_SAT_EN for saturating counters.
module perf_counter_bank #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000,
    localparam int SEL_W     = $clog2(NUM_CH + 2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                inst_retire,
    input  logic                halt,
    input  logic [NUM_CH-1:0]   event_vec,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic [1:0]          state_o,
    output logic                done,
    output logic [NUM_CH+1:0]   ovf_vec
);

    localparam int NCNT = NUM_CH + 2;
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        HALTED  = 2'b10,
        TIMEOUT = 2'b11
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt     [NCNT];
    logic [CNT_W-1:0]  cntNext [NCNT];
    logic [NCNT-1:0]   ovfNext;
    logic [NCNT-1:0]   incVec;
    logic [CNT_W-1:0]  rdNext;
    logic              countEn;
    logic              timeoutHit;

    // Slot 0 is the cycle counter (always increments), slot 1 retired instructions.
    assign incVec  = {event_vec, inst_retire, 1'b1};
    assign countEn = en && (state == IDLE || state == RUN);

    always_comb begin
        timeoutHit = 1'b0;
        if (MAX_CYCLES != 0) begin
            timeoutHit = (64'(cnt[0]) == 64'(MAX_CYCLES) - 64'd1);
        end
    end

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cntNext[i] = cnt[i];
            ovfNext[i] = ovf_vec[i];
            if (countEn && incVec[i]) begin
                if (cnt[i] == ALL_ONES) begin
                    ovfNext[i] = 1'b1;
`ifdef PERF_SAT_EN
                    cntNext[i] = ALL_ONES;
`else
                    cntNext[i] = '0;
`endif
                end else begin
                    cntNext[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Halt is checked last so it wins over a coincident timeout.
    always_comb begin
        stateNext = state;
        if (countEn) begin
            stateNext = RUN;
            if (timeoutHit) begin
                stateNext = TIMEOUT;
            end
            if (halt) begin
                stateNext = HALTED;
            end
        end
    end

    // Readback picks up the pre-update value; unmapped selects read as zero.
    always_comb begin
        rdNext = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdNext = cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
            end
            ovf_vec <= '0;
            rd_data <= '0;
            state   <= IDLE;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= cntNext[i];
            end
            ovf_vec <= ovfNext;
            rd_data <= rdNext;
            state   <= stateNext;
        end
    end

    assign state_o = state;
    assign done    = (state == HALTED) || (state == TIMEOUT);

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised performance-monitor block for the pipelined CPU; replaces bench-only stat counting.
- Counts cycles, retired instructions and NUM_CH generic event channels (e.g. I/D cache req/hit) from the point it is enabled until halt or timeout, then freezes all counts.
- Sits beside the cpu top level. Pipeline and cache probes feed event_vec; rd_sel/rd_data give registered readback for benches or a debug port.

Parameters:
- NUM_CH, 4, number of generic event channels (1..14).
- CNT_W, 32, width of every counter, cycle counter included (8..64).
- MAX_CYCLES, 100000, cycle limit that triggers timeout; 0 disables timeout.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  count enable.
- clr  input  1  synchronous clear of counters and state.
- inst_retire  input  1  one instruction retired this cycle (RegWrite | MemWrite | halt).
- halt  input  1  halt reached MEM/WB this cycle.
- event_vec  input  NUM_CH  per-channel event pulses.
- rd_sel  input  SEL_W=$clog2(NUM_CH+2)  readback select.
- rd_data  output  CNT_W  registered readback value.
- state_o  output  2  00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT.
- done  output  1  state is HALTED or TIMEOUT.
- ovf_vec  output  NUM_CH+2  sticky overflow flags: bit0 cycle, bit1 inst, bit2+i channel i.

Behaviour:
- Reset (rst_n=0 at posedge): all counters, rd_data and ovf_vec go to 0; state goes to IDLE; done=0. Reset overrides clr and every other input.
- clr=1 (rst_n=1): same effect as reset. Takes priority over all counting that cycle.
- IDLE -> RUN on the first posedge with en=1. That cycle counts: cycle+1, plus inst/event increments if asserted.
- RUN, en=1, each posedge:
  - cycle_cnt += 1.
  - inst_cnt += inst_retire.
  - ch_cnt[i] += event_vec[i].
- RUN, en=0: all counters hold; halt and timeout are not evaluated.
- RUN with halt=1 and en=1: that cycle's increments are applied, then state -> HALTED.
- Timeout: if MAX_CYCLES != 0, en=1 and cycle_cnt == MAX_CYCLES-1, the increment lands cycle_cnt at MAX_CYCLES and state -> TIMEOUT.
- halt and timeout in the same cycle: HALTED wins.
- HALTED / TIMEOUT: all counters frozen. Ignores en, halt, events. Left only by rst_n or clr.
- Overflow: an increment from all-ones wraps to 0 and sets the matching ovf_vec bit. Bits are sticky until reset/clr. Saturating variant: see Optional Feature.
- Readback: rd_data <= value selected by rd_sel at each posedge, so 1-cycle latency.
  - Select map: 0 cycle_cnt, 1 inst_cnt, 2+i ch_cnt[i]; out of range returns 0.
  - rd_data returns the pre-update value: a counter incrementing in the same cycle returns its old value.
- done is combinational from state.

Optional Feature:
- Macro PERF_SAT_EN.
- Defined: counters saturate at all-ones (2^CNT_W-1) and stay there; the ovf_vec bit is set on the first blocked increment.
- Undefined: counters wrap as described in Behaviour.
- Sticky flags, readback and state machine are identical in both builds.

Test Plan:
- Reset then en=1 for 10 cycles, inst_retire every other cycle, event_vec=4'b0001 every cycle, then halt on cycle 11 with inst_retire=1 -> state HALTED; cycle=11, inst=6, ch0=11; counters stay fixed for 20 more cycles; done=1.
- MAX_CYCLES=50, en=1, no halt -> state TIMEOUT after exactly 50 posedges, cycle_cnt=50, then frozen.
- halt=1 on the same cycle the timeout hits (MAX_CYCLES=20, halt on cycle 20) -> state HALTED, cycle_cnt=20.
- Toggle en 1/0 for 16 cycles with events held high -> all counts = 8; halt while en=0 is ignored (state stays RUN).
- CNT_W=8, event ch1 held 260 cycles -> build without PERF_SAT_EN: ch1=4, ovf_vec[3]=1; build with PERF_SAT_EN: ch1=255, ovf_vec[3]=1.
- Mid-run clr=1 at cycle 7, and separately rst_n=0 at cycle 7 -> next cycle: all counters 0, state IDLE, ovf_vec=0. Then rd_sel=1 gives rd_data=0 one cycle later; recount from en resumes correctly.
